// File: rtl/led_mode_sequencer.sv
// LED mode sequencer: a debounced button steps PASS -> SHIFT -> BLINK -> COUNT,
// and a prescaled tick animates the SHIFT, BLINK and COUNT patterns on the LEDs.
module led_mode_sequencer #(
  parameter int WIDTH        = 16,
  parameter int TICK_DIV     = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_next,
  output logic [WIDTH-1:0] led,
  output logic [1:0]       mode
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    PASS  = 2'b00,
    SHIFT = 2'b01,
    BLINK = 2'b10,
    COUNT = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             btn_s1_q, btn_s1_d;
  logic             btn_s2_q, btn_s2_d;
  logic             btn_db_q, btn_db_d;
  logic [DW-1:0]    db_cnt_q, db_cnt_d;
  logic             next_pulse_q, next_pulse_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             tick;

  assign tick = (tick_cnt_q == TICK_LAST);
  assign led  = led_q;
  assign mode = state_q;

  // Synchronise the button, debounce it and turn the accepted press into a one-cycle pulse.
  always_comb begin
    btn_s1_d     = btn_next;
    btn_s2_d     = btn_s1_q;
    btn_db_d     = btn_db_q;
    db_cnt_d     = '0;
    next_pulse_d = 1'b0;
    if (btn_s2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d     = btn_s2_q;
        next_pulse_d = btn_s2_q;  // only the press edge steps the mode
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Mode FSM, tick prescaler and per-mode animation state; a mode change beats a tick.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    pattern_d  = pattern_q;
    phase_d    = phase_q;
    count_d    = count_q;
    if (next_pulse_q) begin
      tick_cnt_d = '0;
      unique case (state_q)
        PASS: begin
          state_d   = SHIFT;
          pattern_d = (sw == '0) ? ONE_HOT0 : sw;
        end
        SHIFT: begin
          state_d = BLINK;
          phase_d = 1'b0;
        end
        BLINK: begin
          state_d = COUNT;
          count_d = '0;
        end
        COUNT: state_d = PASS;
      endcase
    end else if (tick) begin
      unique case (state_q)
        SHIFT:   pattern_d = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
        BLINK:   phase_d   = ~phase_q;
        COUNT:   count_d   = count_q + 1'b1;
        default: ;
      endcase
    end
  end

  // LED drive selected by the current mode, registered one cycle later.
  always_comb begin
    led_d = '0;
    unique case (state_q)
      PASS:  led_d = sw;
      SHIFT: led_d = pattern_q;
      BLINK: led_d = phase_q ? '0 : sw;
      COUNT: led_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PASS;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      btn_db_q     <= 1'b0;
      db_cnt_q     <= '0;
      next_pulse_q <= 1'b0;
      tick_cnt_q   <= '0;
      pattern_q    <= '0;
      phase_q      <= 1'b0;
      count_q      <= '0;
      led_q        <= '0;
    end else begin
      state_q      <= state_d;
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      btn_db_q     <= btn_db_d;
      db_cnt_q     <= db_cnt_d;
      next_pulse_q <= next_pulse_d;
      tick_cnt_q   <= tick_cnt_d;
      pattern_q    <= pattern_d;
      phase_q      <= phase_d;
      count_q      <= count_d;
      led_q        <= led_d;
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: directed scenarios then random switches/button/reset,
// all compared every cycle against a behavioural model of the LED controller.
module tb_led_mode_sequencer;

  localparam int WIDTH        = 16;
  localparam int TICK_DIV     = 4;
  localparam int DEBOUNCE_CYC = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] sw;
  logic             btn_next;
  logic [WIDTH-1:0] led;
  logic [1:0]       mode;

  int vectors     = 0;
  int miscompares = 0;

  led_mode_sequencer #(
    .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn_next(btn_next), .led(led), .mode(mode)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic             m_s1, m_s2, m_db, m_pulse, m_phase;
  int               m_dc, m_tick;
  logic [1:0]       m_mode;
  logic [WIDTH-1:0] m_pat, m_cnt, m_led;

  // Behavioural model: every quantity below is the value after this rising edge.
  always @(posedge clk) begin
    logic np, tk, newp;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_pulse = 0; m_phase = 0;
      m_dc = 0; m_tick = 0; m_mode = 0; m_pat = 0; m_cnt = 0; m_led = 0;
    end else begin
      np = m_pulse;
      tk = (m_tick == TICK_DIV - 1);
      case (m_mode)
        2'd0:    m_led = sw;
        2'd1:    m_led = m_pat;
        2'd2:    m_led = m_phase ? '0 : sw;
        default: m_led = m_cnt;
      endcase
      if (np) begin
        m_mode = m_mode + 2'd1;
        m_tick = 0;
        case (m_mode)
          2'd1:    m_pat = (sw == 0) ? 16'h0001 : sw;
          2'd2:    m_phase = 0;
          2'd3:    m_cnt = 0;
          default: ;
        endcase
      end else begin
        m_tick = (m_tick + 1) % TICK_DIV;
        if (tk) begin
          case (m_mode)
            2'd1:    m_pat = (m_pat << 1) | (m_pat >> (WIDTH - 1));
            2'd2:    m_phase = ~m_phase;
            2'd3:    m_cnt = m_cnt + 16'h1;
            default: ;
          endcase
        end
      end
      newp = 0;
      if (m_s2 != m_db) begin
        m_dc = m_dc + 1;
        if (m_dc == DEBOUNCE_CYC) begin
          m_db = m_s2;
          m_dc = 0;
          newp = m_s2;
        end
      end else begin
        m_dc = 0;
      end
      m_pulse = newp;
      m_s2 = m_s1;
      m_s1 = btn_next;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, then compare outputs against the model on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("led_model", 32'(led), 32'(m_led));
    chk("mode_model", 32'(mode), 32'(m_mode));
  endtask

  task automatic press();
    btn_next = 1'b1;
    repeat (10) step();
    btn_next = 1'b0;
    repeat (8) step();
  endtask

  // Raise the button and stop on the cycle the new mode's initial LED value appears.
  task automatic press_entry();
    btn_next = 1'b1;
    repeat (7) step();
  endtask

  task automatic release_btn();
    btn_next = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    reset = 1'b1; sw = 16'hFFFF; btn_next = 1'b0;
    @(negedge clk);

    // Reset
    repeat (2) step();
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_mode", 32'(mode), 32'h0);
    reset = 1'b0;
    step();
    chk("pass_after_reset", 32'(led), 32'hFFFF);

    // Debounce: bounce then hold gives exactly one step
    btn_next = 1'b1; step();
    btn_next = 1'b0; step();
    btn_next = 1'b1;
    repeat (10) step();
    chk("debounce_one_step", 32'(mode), 32'h1);
    release_btn();
    chk("release_ignored", 32'(mode), 32'h1);
    btn_next = 1'b1;
    repeat (10) step();
    chk("second_press", 32'(mode), 32'h2);
    release_btn();
    press();
    press();
    chk("back_to_pass", 32'(mode), 32'h0);

    // SHIFT entry and rotation
    sw = 16'h8001;
    press_entry();
    chk("shift_entry", 32'(led), 32'h8001);
    repeat (4) step();
    chk("shift_rot1", 32'(led), 32'h0003);
    repeat (4) step();
    chk("shift_rot2", 32'(led), 32'h0006);
    release_btn();
    press(); press(); press();
    sw = 16'h0000;
    press_entry();
    chk("shift_zero_entry", 32'(led), 32'h0001);
    release_btn();

    // BLINK
    sw = 16'h00F0;
    press_entry();
    chk("blink_on", 32'(led), 32'h00F0);
    repeat (4) step();
    chk("blink_off", 32'(led), 32'h0000);
    repeat (4) step();
    chk("blink_on_again", 32'(led), 32'h00F0);
    sw = 16'h0F00;
    step();
    chk("blink_live_sw", 32'(led), 32'h0F00);
    release_btn();

    // COUNT with wrap
    press_entry();
    chk("count_entry", 32'(led), 32'h0000);
    release_btn();
    while (m_tick != 0) step();
    force dut.count_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    step();
    release dut.count_q;
    repeat (4) step();
    chk("count_ffff", 32'(led), 32'hFFFF);
    repeat (4) step();
    chk("count_wrap", 32'(led), 32'h0000);
    sw = 16'h1234;
    press_entry();
    chk("count_to_pass_mode", 32'(mode), 32'h0);
    chk("count_to_pass_led", 32'(led), 32'h1234);
    release_btn();

    // Collision of mode change and tick in SHIFT
    sw = 16'h00A5;
    press_entry();
    chk("shift_entry_a5", 32'(led), 32'h00A5);
    release_btn();
    repeat (3) step();
    while (((m_tick + 5) % TICK_DIV) != TICK_DIV - 1) step();
    btn_next = 1'b1;
    repeat (6) step();
    chk("collision_mode", 32'(mode), 32'h2);
    chk("collision_pattern", 32'(dut.pattern_q), 32'(m_pat));
    step();
    chk("collision_blink_on", 32'(led), 32'h00A5);
    repeat (3) step();
    chk("collision_still_on", 32'(led), 32'h00A5);
    step();
    chk("collision_first_toggle", 32'(led), 32'h0000);
    release_btn();
    press();
    chk("in_count", 32'(mode), 32'h3);
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("midcount_reset_led", 32'(led), 32'h0);
    chk("midcount_reset_mode", 32'(mode), 32'h0);
    reset = 1'b0;
    step();

    // Random switches, button activity and occasional reset
    for (int i = 0; i < 1500; i++) begin
      sw = 16'($urandom);
      if ($urandom_range(15, 0) == 0) btn_next = ~btn_next;
      reset = ($urandom_range(299, 0) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
